// File: rtl/temp_sensor_pkg.sv
// Shared types and constants for the temp_sensor sweep generator and its jitter LFSR.
package temp_sensor_pkg;

  typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 as a mask over state[7:0]
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  localparam int         TICK_DIV_DEF  = 4;
  localparam logic [7:0] TEMP_INIT_DEF = 8'd20;
  localparam logic [7:0] TEMP_MIN_DEF  = 8'd15;
  localparam logic [7:0] TEMP_MAX_DEF  = 8'd29;
  localparam logic [7:0] STEP_DEF      = 8'd2;

endpackage

// File: rtl/temp_lfsr.sv
// 8-bit Fibonacci LFSR, shifts once per cycle with advance high; reloads the seed on Reset.
module temp_lfsr
  import temp_sensor_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       advance,
  output logic [7:0] state
);

  logic fb;

  assign fb = ^(state & LFSR_TAPS);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state <= LFSR_SEED;
    end else if (advance) begin
      state <= {state[6:0], fb};
    end
  end

endmodule

// File: rtl/temp_sensor.sv
// Synthetic temperature source: triangle sweep between TEMP_MIN and TEMP_MAX, one step per tick.
// Optional +/-1 jitter from an LFSR when TEMP_SENSOR_NOISE_EN is defined.
//
// state | meaning
// UP    | core rises by STEP per tick, clamped at TEMP_MAX
// DOWN  | core falls by STEP per tick, clamped at TEMP_MIN
module temp_sensor
  import temp_sensor_pkg::*;
#(
  parameter int         TICK_DIV  = TICK_DIV_DEF,
  parameter logic [7:0] TEMP_INIT = TEMP_INIT_DEF,
  parameter logic [7:0] TEMP_MIN  = TEMP_MIN_DEF,
  parameter logic [7:0] TEMP_MAX  = TEMP_MAX_DEF,
  parameter logic [7:0] STEP      = STEP_DEF
) (
  input  logic       Clock,
  input  logic       Reset,
  output logic       tick,
  output logic [7:0] temp
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  if (!(TEMP_MIN < TEMP_MAX)) begin : g_err_range
    $error("temp_sensor: TEMP_MIN must be below TEMP_MAX");
  end
  if (TEMP_INIT < TEMP_MIN || TEMP_INIT > TEMP_MAX) begin : g_err_init
    $error("temp_sensor: TEMP_INIT outside TEMP_MIN..TEMP_MAX");
  end
  if (TICK_DIV < 2) begin : g_err_div
    $error("temp_sensor: TICK_DIV must be at least 2");
  end
  if (STEP < 8'd1) begin : g_err_step
    $error("temp_sensor: STEP must be at least 1");
  end

  logic [CW-1:0] cnt_q;
  logic          wrap;
  logic [7:0]    core_q, core_d;
  dir_e          dir_q, dir_d;
  logic [8:0]    up_sum, dn_diff;

  assign wrap = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q  <= '0;
      tick   <= 1'b0;
      core_q <= TEMP_INIT;
      dir_q  <= UP;
    end else begin
      cnt_q  <= wrap ? '0 : cnt_q + CW'(1);
      tick   <= wrap;
      core_q <= core_d;
      dir_q  <= dir_d;
    end
  end

  // Core sitting at TEMP_MAX while in UP only happens straight out of reset; treat it as DOWN.
  always_comb begin
    dir_d   = dir_q;
    core_d  = core_q;
    up_sum  = {1'b0, core_q} + {1'b0, STEP};
    dn_diff = {1'b0, core_q} - {1'b0, STEP};
    if (wrap) begin
      if (dir_q == UP && core_q != TEMP_MAX) begin
        if (up_sum >= {1'b0, TEMP_MAX}) begin
          core_d = TEMP_MAX;
          dir_d  = DOWN;
        end else begin
          core_d = up_sum[7:0];
        end
      end else begin
        if (dn_diff[8] || dn_diff <= {1'b0, TEMP_MIN}) begin
          core_d = TEMP_MIN;
          dir_d  = UP;
        end else begin
          core_d = dn_diff[7:0];
          dir_d  = DOWN;
        end
      end
    end
  end

`ifdef TEMP_SENSOR_NOISE_EN
  logic [7:0] lfsr_state;

  temp_lfsr u_lfsr (
    .Clock   (Clock),
    .Reset   (Reset),
    .advance (wrap),
    .state   (lfsr_state)
  );

  // core and LFSR both move on the tick edge, so this stays stable between ticks
  always_comb begin
    temp = core_q;
    case (lfsr_state[1:0])
      2'b00:   if (core_q > TEMP_MIN) temp = core_q - 8'd1;
      2'b11:   if (core_q < TEMP_MAX) temp = core_q + 8'd1;
      default: temp = core_q;
    endcase
  end
`else
  assign temp = core_q;
`endif

endmodule

// File: tb/tb_temp_sensor.sv
// Scoreboard bench for temp_sensor: expected tick samples are queued up front and popped on each tick.
module tb_temp_sensor;

  logic       Clock;
  logic       Reset;
  logic       tick;
  logic [7:0] temp;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  temp_sensor dut (
    .Clock (Clock),
    .Reset (Reset),
    .tick  (tick),
    .temp  (temp)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_val(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

`ifdef TEMP_SENSOR_NOISE_EN
  localparam int NTICKS = 200;
`else
  localparam int NTICKS = 14;
`endif

  initial begin
    int last_temp;
    int n_ticks40;
    int exp_t;
`ifdef TEMP_SENSOR_NOISE_EN
    int m_core;
    bit m_up;
    logic [7:0] m_lfsr;
    logic m_fb;
`else
    int seq[14] = '{22, 24, 26, 28, 29, 27, 25, 23, 21, 19, 17, 15, 17, 19};
`endif

    // Expected temp at each tick, queued before the run
`ifdef TEMP_SENSOR_NOISE_EN
    m_core = 20; m_up = 1'b1; m_lfsr = 8'hA5;
    for (int k = 0; k < NTICKS; k++) begin
      if (m_up) begin
        m_core = (m_core + 2 >= 29) ? 29 : m_core + 2;
        if (m_core == 29) m_up = 1'b0;
      end else begin
        m_core = (m_core - 2 <= 15) ? 15 : m_core - 2;
        if (m_core == 15) m_up = 1'b1;
      end
      m_fb = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
      m_lfsr = {m_lfsr[6:0], m_fb};
      exp_t = m_core;
      if (m_lfsr[1:0] == 2'b00 && m_core > 15) exp_t = m_core - 1;
      if (m_lfsr[1:0] == 2'b11 && m_core < 29) exp_t = m_core + 1;
      exp_q.push_back(exp_t);
    end
`else
    foreach (seq[i]) exp_q.push_back(seq[i]);
`endif

    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_val("reset_temp", temp, 20);
    check_val("reset_tick", tick, 0);
    Reset = 1'b0;

    last_temp = 20;
    n_ticks40 = 0;
    for (int c = 1; c <= NTICKS * 4; c++) begin
      @(negedge Clock);
      check_val($sformatf("tick_c%0d", c), tick, (c % 4 == 0) ? 1 : 0);
      if (c <= 40 && tick) n_ticks40++;
      if (tick) begin
        if (exp_q.size() == 0) begin
          check_val("sb_underflow", 1, 0);
        end else begin
          exp_t = exp_q.pop_front();
          check_val($sformatf("temp_tick_c%0d", c), temp, exp_t);
        end
`ifdef TEMP_SENSOR_NOISE_EN
        check_val("temp_in_range", (temp >= 15 && temp <= 29) ? 1 : 0, 1);
`endif
        last_temp = temp;
      end else begin
        check_val($sformatf("temp_hold_c%0d", c), temp, last_temp);
      end
    end
    check_val("ticks_in_40", n_ticks40, 10);
    check_val("sb_empty", exp_q.size(), 0);

`ifndef TEMP_SENSOR_NOISE_EN
    // Mid-sweep reset while descending through 27
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_val("rst2_temp", temp, 20);
    repeat (24) @(negedge Clock);
    check_val("pre_rst_tick", tick, 1);
    check_val("pre_rst_temp", temp, 27);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    check_val("midrst_temp", temp, 20);
    check_val("midrst_tick", tick, 0);
    repeat (3) begin
      @(negedge Clock);
      check_val("post_rst_idle_tick", tick, 0);
      check_val("post_rst_idle_temp", temp, 20);
    end
    @(negedge Clock);
    check_val("post_rst_tick", tick, 1);
    check_val("post_rst_temp", temp, 22);
    repeat (4) @(negedge Clock);
    check_val("post_rst_up_temp", temp, 24);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
